ex_div: RTL

Multi-cycle 32-bit integer divider for the EX stage. It consumes the operands that the ID/EX pipeline register delivers for DIV/DIVU, and iterates one quotient bit per clock using restoring division. It returns the 64-bit {remainder, quotient} pair for the HI/LO write path. While a division is in flight, EX holds `start_i` high and requests a pipeline stall until `ready_o` rises.

---
 rtl/ex_div_pkg.sv | 18 +
 rtl/ex_div.sv | 108 ++++++++++
 2 files changed

// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared state encodings and control constants for ex_div
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic RST_ENABLE          = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic [5:0] DIV_ITERS      = 6'd32;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle 32-bit restoring divider returning {remainder, quotient}
module ex_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state, state_next;
  logic [5:0]  cnt;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic        sign1, sign2, sdiv;
  logic [32:0] diff;
  logic [31:0] abs1, abs2, q_fix, r_fix;
  logic        go;

  assign go   = (start_i == DIV_START) && !annul_i;
  assign diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
  assign abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  // Signs come from the operands captured at start, not the live inputs
  assign q_fix = (sdiv && (sign1 ^ sign2)) ? -dividend[31:0] : dividend[31:0];
  assign r_fix = (sdiv && sign1) ? -dividend[64:33] : dividend[64:33];

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) state <= DIV_FREE;
    else                     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_FREE: begin
        if (go) state_next = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: state_next = DIV_END;
      DIV_ON: begin
        if (annul_i)                state_next = DIV_FREE;
        else if (cnt == DIV_ITERS)  state_next = DIV_END;
      end
      DIV_END: begin
        if (start_i == DIV_STOP) state_next = DIV_FREE;
      end
      default: state_next = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      cnt      <= 6'd0;
      dividend <= 65'd0;
      divisor  <= 32'd0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sdiv     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= 64'd0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (go && opdata2_i != 32'd0) begin
            dividend <= {32'd0, abs1, 1'b0};
            divisor  <= abs2;
            sign1    <= opdata1_i[31];
            sign2    <= opdata2_i[31];
            sdiv     <= signed_div_i;
            cnt      <= 6'd0;
          end
        end
        DIV_BY_ZERO: dividend <= 65'd0;
        DIV_ON: begin
          if (annul_i) begin
            cnt <= 6'd0;
          end else if (cnt != DIV_ITERS) begin
            if (diff[32]) dividend <= {dividend[63:0], 1'b0};
            else          dividend <= {diff[31:0], dividend[31:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            // Corrected pair is parked in place so DivEnd just publishes it
            dividend <= {r_fix, 1'b0, q_fix};
            cnt      <= 6'd0;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            result_o <= 64'd0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            result_o <= {dividend[64:33], dividend[31:0]};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
